// File: rtl/alu_pkg.sv
// Shared opcode map and flag bit positions for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_FWDA = 4'h0;
  localparam logic [3:0] OP_FWDB = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_ADC  = 4'h8;
  localparam logic [3:0] OP_SBC  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_SRA  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_CLC  = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  // flags bus is {Z,N,C,V}
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared adder for ADD/SUB/ADC/SBC/CMP plus logic and shifts.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             err,
  output logic             carry_upd
);

  logic [WIDTH-1:0] bp;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   sra;
  logic [SH_W-1:0]  sh;
  logic             ovf;
  logic             c;
  logic             v;
  logic [WIDTH-1:0] zn_src;

  always_comb begin
    bp  = b;
    cin = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin bp = ~b; cin = 1'b1;     end
      OP_ADC:         begin          cin = carry_in; end
      OP_SBC:         begin bp = ~b; cin = carry_in; end
      default: ;
    endcase

    sum = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, cin};
    ovf = (a[WIDTH-1] == bp[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

    // Shifts run one bit wider so the extra bit holds the last bit shifted out.
    sh  = b[SH_W-1:0];
    shl = {1'b0, a} << sh;
    shr = {a, 1'b0} >> sh;
    sra = $signed({a, 1'b0}) >>> sh;

    res       = '0;
    c         = 1'b0;
    v         = 1'b0;
    err       = 1'b0;
    carry_upd = 1'b0;
    case (op)
      OP_FWDA: res = a;
      OP_FWDB: res = b;
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        res = sum[WIDTH-1:0]; c = sum[WIDTH]; v = ovf; carry_upd = 1'b1;
      end
      OP_CMP: begin
        res = a; c = sum[WIDTH]; v = ovf; carry_upd = 1'b1;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL:  begin res = shl[WIDTH-1:0]; c = shl[WIDTH]; carry_upd = 1'b1; end
      OP_SHR:  begin res = shr[WIDTH:1];   c = shr[0];     carry_upd = 1'b1; end
      OP_SRA:  begin res = sra[WIDTH:1];   c = sra[0];     carry_upd = 1'b1; end
      OP_CLC:  carry_upd = 1'b1;
      default: err = 1'b1;
    endcase

    zn_src = (op == OP_CMP) ? sum[WIDTH-1:0] : res;
    flags         = '0;
    flags[FLG_Z]  = (zn_src == '0);
    flags[FLG_N]  = zn_src[WIDTH-1];
    flags[FLG_C]  = c;
    flags[FLG_V]  = v;
    if (err) flags = '0;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 captures operands, S2 registers result/flags, plus sticky carry.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             err
);

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             carry_q, carry_d;

  logic             s2_adv;
  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flags;
  logic             core_err;
  logic             core_upd;

  alu_core #(.WIDTH(WIDTH), .SH_W(SH_W)) u_core (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .carry_in  (carry_q),
    .res       (core_res),
    .flags     (core_flags),
    .err       (core_err),
    .carry_upd (core_upd)
  );

  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        op_d = op;
        a_d  = in_a;
        b_d  = in_b;
      end
    end

    // carry_q moves with the S1->S2 transfer so the next op in S1 already sees it.
    out_valid_d = out_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    err_d       = err_q;
    carry_d     = carry_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d   = core_res;
        flags_d = core_flags;
        err_d   = core_err;
        if (core_upd) carry_d = core_flags[FLG_C];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: hand-computed results are queued and matched on each output handshake.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] res;
  logic [3:0] flags;
  logic       err;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad = 0;

  alu_pipe #(.WIDTH(8), .OP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input logic [7:0] r, input logic [3:0] f, input logic e);
    exp_t x;
    x.res = r; x.flags = f; x.err = e;
    exp_q.push_back(x);
  endtask

  // Present one op and hold it until an edge accepts it; returns 1 time unit after that edge.
  task automatic send(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; op = o; in_a = a; in_b = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  // Output monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {24'd0, res}, 32'hDEAD);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("res",   {24'd0, res},   {24'd0, x.res});
        check("flags", {28'd0, flags}, {28'd0, x.flags});
        check("err",   {31'd0, err},   {31'd0, x.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int accepts;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready",  {31'd0, in_ready},  1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_res",   {24'd0, res},   0);
    check("rst_flags", {28'd0, flags}, 0);
    check("rst_err",   {31'd0, err},   0);
    @(posedge clk); #1;

    // Latency: out_valid low after accept edge, high after the next one
    out_ready = 1'b1;
    expect_out(8'h80, 4'b0101, 1'b0);
    send(OP_ADD, 8'h7F, 8'h01);
    @(negedge clk);
    check("lat_one_edge", {31'd0, out_valid}, 0);
    @(negedge clk);
    check("lat_two_edges", {31'd0, out_valid}, 1);
    drain();

    // SUB then CMP back-to-back
    expect_out(8'h00, 4'b1010, 1'b0);
    expect_out(8'h03, 4'b0100, 1'b0);
    send(OP_SUB, 8'h05, 8'h05);
    send(OP_CMP, 8'h03, 8'h04);
    drain();

    // Multi-word carry chain and CLC
    expect_out(8'h00, 4'b1010, 1'b0);
    expect_out(8'h01, 4'b0000, 1'b0);
    expect_out(8'h00, 4'b1000, 1'b0);
    expect_out(8'h00, 4'b1000, 1'b0);
    send(OP_ADD, 8'hFF, 8'h01);
    send(OP_ADC, 8'h00, 8'h00);
    send(OP_CLC, 8'h00, 8'h00);
    send(OP_ADC, 8'h00, 8'h00);
    drain();

    // Backpressure: 5 ops while out_ready is low for 6 cycles
    out_ready = 1'b0;
    accepts = 0;
    expect_out(8'h02, 4'b0000, 1'b0);
    expect_out(8'h04, 4'b0000, 1'b0);
    expect_out(8'hFF, 4'b0100, 1'b0);
    expect_out(8'h00, 4'b1000, 1'b0);
    expect_out(8'h33, 4'b0000, 1'b0);
    fork
      begin
        send(OP_ADD, 8'h01, 8'h01);
        send(OP_ADD, 8'h02, 8'h02);
        send(OP_XOR, 8'h0F, 8'hF0);
        send(OP_AND, 8'hF0, 8'h0F);
        send(OP_OR,  8'h30, 8'h03);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (in_valid && in_ready) accepts++;
          if (out_valid) check("bp_res_held", {24'd0, res}, 32'h02);
        end
        check("bp_accepts", accepts, 2);
        check("bp_in_ready_low", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Shifts and reserved opcode
    expect_out(8'hF2, 4'b0100, 1'b0);
    expect_out(8'h02, 4'b0010, 1'b0);
    expect_out(8'h40, 4'b0010, 1'b0);
    expect_out(8'h81, 4'b0100, 1'b0);
    expect_out(8'h00, 4'b0000, 1'b1);
    send(OP_SRA, 8'h90, 8'h03);
    send(OP_SHL, 8'h81, 8'h01);
    send(OP_SHR, 8'h81, 8'h01);
    send(OP_SHR, 8'h81, 8'h00);
    send(OP_RSVD, 8'h12, 8'h34);
    drain();

    // Reset with two ops in flight; carry set by the first must be cleared
    out_ready = 1'b0;
    send(OP_ADD, 8'hFF, 8'h01);
    send(OP_ADD, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", {31'd0, out_valid}, 0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    expect_out(8'h00, 4'b1000, 1'b0);
    send(OP_ADC, 8'h00, 8'h00);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
